// File: rtl/alu_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_pkg
// Description : Shared opcode/funct7 constants, alu_control encodings and the
//               decoded-entry record for the ALU decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [6:0] F7_ZERO   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_SLL     = 4'b0010;
    localparam logic [3:0] ALU_SLT     = 4'b0011;
    localparam logic [3:0] ALU_SLTU    = 4'b0100;
    localparam logic [3:0] ALU_XOR     = 4'b0101;
    localparam logic [3:0] ALU_SRL     = 4'b0110;
    localparam logic [3:0] ALU_SRA     = 4'b0111;
    localparam logic [3:0] ALU_OR      = 4'b1000;
    localparam logic [3:0] ALU_AND     = 4'b1001;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    // One decoded instruction as held in the output queue. The immediate is
    // kept at 32 bits; the top widens or narrows it to XLEN at the head.
    typedef struct packed {
        logic [3:0]  ctrl;
        logic        illegal;
        logic        is_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } alu_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_queue_if
// Description : Fetch-side and execute-side handshake bundle of the ALU
//               decode queue. slave = the queue, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_decode_queue_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_alu_control;
    logic              out_illegal;
    logic              out_is_imm;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [XLEN-1:0]   out_imm;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alu_control, out_illegal,
               out_is_imm, out_rd, out_rs1, out_rs2, out_imm
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alu_control, out_illegal,
               out_is_imm, out_rd, out_rs1, out_rs2, out_imm
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational RV32I ALU-instruction decoder (R-type and
//               I-type ALU) producing one queue entry per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_decode_pkg::*;
(
    input  wire logic [31:0] instr,
    output alu_entry_t       entry
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // Decode opcode/funct3/funct7 into the operation; anything unrecognised
    // keeps the raw register fields and the sign-extended I-immediate.
    always_comb begin
        entry.ctrl    = ALU_INVALID;
        entry.illegal = 1'b1;
        entry.is_imm  = (w_opcode == OP_IMM);
        entry.rd      = instr[11:7];
        entry.rs1     = instr[19:15];
        entry.rs2     = instr[24:20];
        entry.imm     = {{20{instr[31]}}, instr[31:20]};

        if (w_opcode == OP_R) begin
            if (w_funct7 == F7_ZERO) begin
                entry.illegal = 1'b0;
                case (w_funct3)
                    3'b000:  entry.ctrl = ALU_ADD;
                    3'b001:  entry.ctrl = ALU_SLL;
                    3'b010:  entry.ctrl = ALU_SLT;
                    3'b011:  entry.ctrl = ALU_SLTU;
                    3'b100:  entry.ctrl = ALU_XOR;
                    3'b101:  entry.ctrl = ALU_SRL;
                    3'b110:  entry.ctrl = ALU_OR;
                    default: entry.ctrl = ALU_AND;
                endcase
            end else if (w_funct7 == F7_ALT) begin
                if (w_funct3 == 3'b000) begin
                    entry.illegal = 1'b0;
                    entry.ctrl    = ALU_SUB;
                end else if (w_funct3 == 3'b101) begin
                    entry.illegal = 1'b0;
                    entry.ctrl    = ALU_SRA;
                end
            end
        end else if (w_opcode == OP_IMM) begin
            case (w_funct3)
                3'b000: begin entry.illegal = 1'b0; entry.ctrl = ALU_ADD;  end
                3'b010: begin entry.illegal = 1'b0; entry.ctrl = ALU_SLT;  end
                3'b011: begin entry.illegal = 1'b0; entry.ctrl = ALU_SLTU; end
                3'b100: begin entry.illegal = 1'b0; entry.ctrl = ALU_XOR;  end
                3'b110: begin entry.illegal = 1'b0; entry.ctrl = ALU_OR;   end
                3'b111: begin entry.illegal = 1'b0; entry.ctrl = ALU_AND;  end
                3'b001: begin
                    if (w_funct7 == F7_ZERO) begin
                        entry.illegal = 1'b0;
                        entry.ctrl    = ALU_SLL;
                        entry.imm     = {27'd0, instr[24:20]};
                    end
                end
                default: begin
                    if (w_funct7 == F7_ZERO) begin
                        entry.illegal = 1'b0;
                        entry.ctrl    = ALU_SRL;
                        entry.imm     = {27'd0, instr[24:20]};
                    end else if (w_funct7 == F7_ALT) begin
                        entry.illegal = 1'b0;
                        entry.ctrl    = ALU_SRA;
                        entry.imm     = {27'd0, instr[24:20]};
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_queue
// Description : Registered RV32I ALU decoder feeding a DEPTH-entry FIFO
//               toward execute, with valid/ready handshakes and flush.
//               Optional illegal-instruction counter: ALU_DECODE_ILLEGAL_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode_queue
    import alu_decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        flush,
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    output logic [15:0]      illegal_count,
`endif
    alu_decode_queue_if.slave bus
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     c_FULL = (AW+1)'(DEPTH);

    alu_entry_t            w_entry;
    alu_entry_t            w_head;
    logic [XLEN-1:0]       w_head_imm;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_out_valid;

    alu_entry_t            r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    alu_ctrl_decode u_decode (
        .instr (bus.in_instr),
        .entry (w_entry)
    );

    assign w_out_valid  = (r_count != '0);
    assign bus.in_ready = (r_count != c_FULL);
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = w_out_valid && bus.out_ready;

    // Pointer and occupancy bookkeeping; flush discards any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; only the occupancy state is cleared.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign w_head_imm = {{(XLEN-32){w_head.imm[31]}}, w_head.imm};
        end else begin : g_imm_narrow
            assign w_head_imm = w_head.imm[XLEN-1:0];
        end
    endgenerate

    // Head fields fall back to their reset values whenever the queue is empty.
    assign bus.out_valid       = w_out_valid;
    assign bus.out_alu_control = (!w_out_valid || w_head.illegal) ? '1 : CTRL_W'(w_head.ctrl);
    assign bus.out_illegal     = w_out_valid ? w_head.illegal : 1'b0;
    assign bus.out_is_imm      = w_out_valid ? w_head.is_imm  : 1'b0;
    assign bus.out_rd          = w_out_valid ? w_head.rd      : 5'd0;
    assign bus.out_rs1         = w_out_valid ? w_head.rs1     : 5'd0;
    assign bus.out_rs2         = w_out_valid ? w_head.rs2     : 5'd0;
    assign bus.out_imm         = w_out_valid ? w_head_imm     : '0;

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [15:0] r_illegal_count;

    // Saturating count of illegal instructions actually accepted; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_count <= '0;
        end else if (w_push && !flush && w_entry.illegal && (r_illegal_count != 16'hFFFF)) begin
            r_illegal_count <= r_illegal_count + 16'd1;
        end
    end

    assign illegal_count = r_illegal_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_decode_queue
// Description : Directed self-checking bench for alu_decode_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_decode_queue;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_errors;
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_count;
`endif

    alu_decode_queue_if #(.XLEN(32), .CTRL_W(4)) bus ();

    alu_decode_queue #(.XLEN(32), .DEPTH(4), .CTRL_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        .illegal_count (illegal_count),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_x(input int r);
        logic [31:0] v;
        v = (32'(r) << 20) | (32'(r) << 7) | 32'h13;
        return v;
    endfunction

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b1;
        flush            = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_instr     = 32'h40208033;
        bus.out_ready    = 1'b0;

        // Reset held two cycles while in_valid is asserted
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_ctrl",      32'(bus.out_alu_control), 32'hF);
        check("rst_illegal",   32'(bus.out_illegal), 32'd0);
        check("rst_imm",       bus.out_imm, 32'd0);

        // R-type SUB
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h40208033;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        check("sub_valid",  32'(bus.out_valid), 32'd1);
        check("sub_ctrl",   32'(bus.out_alu_control), 32'h1);
        check("sub_rs1",    32'(bus.out_rs1), 32'd1);
        check("sub_rs2",    32'(bus.out_rs2), 32'd2);
        check("sub_is_imm", 32'(bus.out_is_imm), 32'd0);
        check("sub_illegal",32'(bus.out_illegal), 32'd0);
        tick();
        check("sub_popped", 32'(bus.out_valid), 32'd0);

        // Illegal funct7 and illegal opcode
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h02208033;
        tick();
        check("ill_f7_ctrl",    32'(bus.out_alu_control), 32'hF);
        check("ill_f7_illegal", 32'(bus.out_illegal), 32'd1);
        bus.in_instr = 32'h00000003;
        tick();
        bus.in_valid = 1'b0;
        check("ill_op_ctrl",    32'(bus.out_alu_control), 32'hF);
        check("ill_op_illegal", 32'(bus.out_illegal), 32'd1);
        check("ill_op_is_imm",  32'(bus.out_is_imm), 32'd0);
        tick();
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        check("illegal_count", 32'(illegal_count), 32'd2);
`endif

        // addi x5,x0,-1 then srai x1,x1,3 (push and pop together)
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFFF00293;
        tick();
        check("addi_ctrl",   32'(bus.out_alu_control), 32'h0);
        check("addi_rd",     32'(bus.out_rd), 32'd5);
        check("addi_is_imm", 32'(bus.out_is_imm), 32'd1);
        check("addi_imm",    bus.out_imm, 32'hFFFFFFFF);
        bus.in_instr = 32'h4030D093;
        tick();
        bus.in_valid = 1'b0;
        check("srai_ctrl", 32'(bus.out_alu_control), 32'h7);
        check("srai_imm",  bus.out_imm, 32'd3);
        check("srai_rd",   32'(bus.out_rd), 32'd1);
        tick();

        // sll x1,x1,x2 and slli with funct7 0x20 (illegal)
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h002090B3;
        tick();
        check("sll_ctrl", 32'(bus.out_alu_control), 32'h2);
        bus.in_instr = 32'h40309093;
        tick();
        bus.in_valid = 1'b0;
        check("slli_f7_illegal", 32'(bus.out_illegal), 32'd1);
        tick();

        // Backpressure: fill four entries, fifth refused
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = addi_x(i);
            tick();
        end
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_instr = addi_x(5);
        tick();
        check("full_refused", 32'(bus.in_ready), 32'd0);
        check("full_head_rd", 32'(bus.out_rd), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_rd%0d", i),  32'(bus.out_rd), 32'(i));
            check($sformatf("drain_imm%0d", i), bus.out_imm, 32'(i));
            tick();
            if (i == 1) check("ready_after_pop", 32'(bus.in_ready), 32'd1);
        end
        check("drained", 32'(bus.out_valid), 32'd0);

        // Flush with three queued entries, concurrent push and pop
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = addi_x(i);
            tick();
        end
        flush         = 1'b1;
        bus.in_instr  = addi_x(7);
        bus.out_ready = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid",    32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_ctrl",     32'(bus.out_alu_control), 32'hF);
        tick();
        check("flush_dropped",  32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_instr = addi_x(9);
        tick();
        bus.in_valid = 1'b0;
        check("post_flush_valid", 32'(bus.out_valid), 32'd1);
        check("post_flush_rd",    32'(bus.out_rd), 32'd9);
        check("post_flush_imm",   bus.out_imm, 32'd9);
        check("post_flush_ctrl",  32'(bus.out_alu_control), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
